dac_wave_generator: RTL and testbench

- Multi-channel waveform generator for AD56x3-class DAC drivers, used for bring-up and loopback testing.
- Emits one sample per channel per sample period on an Avalon ST source, with a channel number on each beat.
- Waveform mode (saw up/down, triangle, square, constant) and step are runtime-configurable per channel.
- Provides proper backpressure (valid held until accepted) and a sticky overrun flag.

---
 rtl/dac_wave_generator_if.sv | 18 +
 rtl/dac_wave_generator.sv | 162 ++++++++++++++++
 tb/tb_dac_wave_generator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_wave_generator_if.sv
// Avalon ST source bundle for the DAC waveform generator: one sample beat
// carrying the channel number alongside the unsigned sample value.
interface dac_wave_generator_if #(
    parameter int DATA_WIDTH   = 14,
    parameter int NUM_CHANNELS = 2
);
    localparam int CH_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    // A beat transfers on any cycle where asoValid and asoRdy are both high;
    // once raised, asoValid/asoChannel/asoData hold unchanged until that cycle.
    logic                  asoValid;
    logic [CH_WIDTH-1:0]   asoChannel;
    logic [DATA_WIDTH-1:0] asoData;
    logic                  asoRdy;

    modport master (output asoValid, output asoChannel, output asoData, input asoRdy);
    modport slave  (input asoValid, input asoChannel, input asoData, output asoRdy);
endinterface

// File: rtl/dac_wave_generator.sv
// Multi-channel bring-up waveform source: once per sample period it emits one
// beat per channel (saw, triangle, square or constant) with full backpressure.
module dac_wave_generator #(
    parameter int CE_DIVIDER    = 125,
    parameter int DATA_WIDTH    = 14,
    parameter int NUM_CHANNELS  = 2,
    parameter int INCREASE_RATE = 1,
    localparam int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfgWrite,
    input  logic [CH_WIDTH-1:0]   cfgChannel,
    input  logic [2:0]            cfgMode,
    input  logic [DATA_WIDTH-1:0] cfgStep,
    input  logic                  clrOverrun,
    dac_wave_generator_if.master  aso,
    output logic                  overrun,
    output logic                  fsm_state
);
    localparam int DIV_W = (CE_DIVIDER > 1) ? $clog2(CE_DIVIDER) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CE_DIVIDER - 1);
    localparam logic [CH_WIDTH-1:0]   CH_LAST  = CH_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [DATA_WIDTH-1:0] MAX      = '1;

    localparam logic [2:0] M_SAW_UP   = 3'd0;
    localparam logic [2:0] M_SAW_DOWN = 3'd1;
    localparam logic [2:0] M_TRIANGLE = 3'd2;
    localparam logic [2:0] M_SQUARE   = 3'd3;
    localparam logic [2:0] M_CONST    = 3'd4;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                state;
    logic [DIV_W-1:0]      divider;
    logic [DATA_WIDTH-1:0] acc  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] step [NUM_CHANNELS];
    logic [2:0]            mode [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] dir_down;
    logic                  skip_update;

    logic                  tick;
    logic                  handshake;
    logic                  cfg_hit;
    logic [CH_WIDTH-1:0]   cur_ch;
    logic [CH_WIDTH-1:0]   load_ch;
    logic [DATA_WIDTH-1:0] load_sample;
    logic                  hs_update;

    function automatic logic [DATA_WIDTH-1:0] sample_of(
        input logic [2:0] m, input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] s);
        case (m)
            M_SAW_UP, M_SAW_DOWN, M_TRIANGLE: sample_of = a;
            M_SQUARE:                         sample_of = a[DATA_WIDTH-1] ? MAX : '0;
            M_CONST:                          sample_of = s;
            default:                          sample_of = '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] next_acc(
        input logic [2:0] m, input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] s,
        input logic d);
        case (m)
            M_SAW_UP, M_SQUARE: next_acc = a + s;
            M_SAW_DOWN:         next_acc = a - s;
            M_TRIANGLE: begin
                if (!d) next_acc = (a >= MAX - s) ? MAX : a + s;
                else    next_acc = (a <= s) ? '0 : a - s;
            end
            default:            next_acc = a;
        endcase
    endfunction

    function automatic logic next_dir(
        input logic [2:0] m, input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] s,
        input logic d);
        if (m == M_TRIANGLE) begin
            if (!d) next_dir = (a >= MAX - s);
            else    next_dir = !(a <= s);
        end else begin
            next_dir = d;
        end
    endfunction

    always_comb begin
        tick      = (divider == DIV_LAST);
        handshake = aso.asoValid & aso.asoRdy;
        cfg_hit   = cfgWrite && (32'(cfgChannel) < NUM_CHANNELS);
        cur_ch    = aso.asoChannel;
        load_ch   = (state == IDLE) ? '0 : cur_ch + CH_WIDTH'(1);
        // A config landing on the beat being loaded this edge must shape that beat.
        if (cfg_hit && cfgChannel == load_ch)
            load_sample = sample_of(cfgMode, '0, cfgStep);
        else
            load_sample = sample_of(mode[load_ch], acc[load_ch], step[load_ch]);
        hs_update = handshake && !skip_update && !(cfg_hit && cfgChannel == cur_ch);
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            divider        <= '0;
            aso.asoValid   <= 1'b0;
            aso.asoChannel <= '0;
            aso.asoData    <= '0;
            overrun        <= 1'b0;
            skip_update    <= 1'b0;
            dir_down       <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                acc[i]  <= '0;
                mode[i] <= M_SAW_UP;
                step[i] <= DATA_WIDTH'(INCREASE_RATE);
            end
        end else begin
            divider <= tick ? '0 : divider + DIV_W'(1);
            if (clrOverrun) overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state          <= SEND;
                        aso.asoValid   <= 1'b1;
                        aso.asoChannel <= '0;
                        aso.asoData    <= load_sample;
                    end
                end
                SEND: begin
                    if (tick) overrun <= 1'b1;
                    if (handshake) begin
                        skip_update <= 1'b0;
                        if (hs_update) begin
                            acc[cur_ch]      <= next_acc(mode[cur_ch], acc[cur_ch], step[cur_ch], dir_down[cur_ch]);
                            dir_down[cur_ch] <= next_dir(mode[cur_ch], acc[cur_ch], step[cur_ch], dir_down[cur_ch]);
                        end
                        if (cur_ch == CH_LAST) begin
                            aso.asoValid <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            aso.asoChannel <= load_ch;
                            aso.asoData    <= load_sample;
                        end
                    end else if (cfg_hit && cfgChannel == cur_ch) begin
                        // The stalled beat predates the new config, so its
                        // eventual handshake must not advance the fresh accumulator.
                        skip_update <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (cfg_hit) begin
                mode[cfgChannel]     <= cfgMode;
                step[cfgChannel]     <= cfgStep;
                acc[cfgChannel]      <= '0;
                dir_down[cfgChannel] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dac_wave_generator.sv
// Directed bench for dac_wave_generator (2 channels, 4-bit samples, period 8)
// with a queue scoreboard checked by an independent beat monitor.
module tb_dac_wave_generator;
    localparam int DW = 4;
    localparam int NC = 2;
    localparam int CE = 8;
    localparam int CW = 1;
    localparam int W  = CW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          cfgWrite;
    logic [CW-1:0] cfgChannel;
    logic [2:0]    cfgMode;
    logic [DW-1:0] cfgStep;
    logic          clrOverrun;
    logic          overrun;
    logic          fsm_state;

    dac_wave_generator_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC)) aso ();

    dac_wave_generator #(
        .CE_DIVIDER(CE), .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .INCREASE_RATE(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfgWrite(cfgWrite),
        .cfgChannel(cfgChannel), .cfgMode(cfgMode), .cfgStep(cfgStep),
        .clrOverrun(clrOverrun), .aso(aso), .overrun(overrun), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_ch0    = -1;
    bit timing_on   = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    int tri_exp [8] = '{0, 5, 10, 15, 10, 5, 0, 5};
    int sdn_exp [8] = '{0, 13, 10, 7, 4, 1, 14, 11};
    int sqr_exp [8] = '{0, 0, 15, 15, 0, 0, 15, 15};

    // Monitor: every accepted beat is checked against the head of the queue.
    always @(negedge clk) begin
        cyc++;
        if (!reset && aso.asoValid && aso.asoRdy) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got ch=%0d data=%0d, required no beat",
                         aso.asoChannel, aso.asoData);
            end else begin
                exp_v = exp_q.pop_front();
                if ({aso.asoChannel, aso.asoData} !== exp_v) begin
                    miscompares++;
                    $display("FAIL beat: got ch=%0d data=%0d, required ch=%0d data=%0d",
                             aso.asoChannel, aso.asoData, exp_v[W-1 -: CW], exp_v[DW-1:0]);
                end
            end
            if (timing_on) begin
                if (aso.asoChannel == 0) begin
                    if (last_ch0 >= 0) begin
                        vectors++;
                        if (cyc - last_ch0 != CE) begin
                            miscompares++;
                            $display("FAIL frame_period: got %0d cycles, required %0d", cyc - last_ch0, CE);
                        end
                    end
                    last_ch0 = cyc;
                end else begin
                    vectors++;
                    if (cyc - last_ch0 != 1) begin
                        miscompares++;
                        $display("FAIL back_to_back: got gap %0d, required 1", cyc - last_ch0);
                    end
                end
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int ch, input int d);
        exp_q.push_back({CW'(ch), DW'(d)});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step_cyc();
            n++;
        end
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_beat(input string name, input int ch, input int budget);
        int n = 0;
        while (!(aso.asoValid && aso.asoChannel == CW'(ch)) && n < budget) begin
            step_cyc();
            n++;
        end
        check({name, "_beat_seen"}, 32'(aso.asoValid && aso.asoChannel == CW'(ch)), 32'd1);
    endtask

    task automatic cfg(input int ch, input int m, input int s);
        cfgChannel = CW'(ch);
        cfgMode    = 3'(m);
        cfgStep    = DW'(s);
        cfgWrite   = 1'b1;
        step_cyc();
        cfgWrite   = 1'b0;
    endtask

    task automatic pulse_clr();
        clrOverrun = 1'b1;
        step_cyc();
        clrOverrun = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; cfgWrite = 1'b0; cfgChannel = '0;
        cfgMode = '0; cfgStep = '0; clrOverrun = 1'b0; aso.asoRdy = 1'b1;
        repeat (3) step_cyc();
        check("reset_valid", 32'(aso.asoValid), 32'd0);
        check("reset_channel", 32'(aso.asoChannel), 32'd0);
        check("reset_data", 32'(aso.asoData), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);

        // Default saw-up on both channels, wrapping after 15.
        for (int i = 0; i < 17; i++) begin
            push(0, i % 16);
            push(1, i % 16);
        end
        timing_on = 1'b1;
        reset = 1'b0;
        enable = 1'b1;
        drain("saw_default", 17 * CE + 16);
        enable = 1'b0;
        timing_on = 1'b0;
        check("saw_overrun", 32'(overrun), 32'd0);

        // Triangle on ch0, saw-down on ch1.
        cfg(0, 2, 5);
        cfg(1, 1, 3);
        for (int i = 0; i < 8; i++) begin
            push(0, tri_exp[i]);
            push(1, sdn_exp[i]);
        end
        enable = 1'b1;
        drain("tri_sawdown", 8 * CE + 16);
        enable = 1'b0;

        // Square on ch0, constant 9 on ch1.
        cfg(0, 3, 4);
        cfg(1, 4, 9);
        for (int i = 0; i < 8; i++) begin
            push(0, sqr_exp[i]);
            push(1, 9);
        end
        enable = 1'b1;
        drain("square_const", 8 * CE + 16);
        enable = 1'b0;
        check("square_overrun", 32'(overrun), 32'd0);

        // Stall ch0 for 20 cycles across a tick.
        cfg(0, 0, 1);
        cfg(1, 0, 1);
        aso.asoRdy = 1'b0;
        enable = 1'b1;
        wait_beat("stall0", 0, 2 * CE);
        check("stall_overrun_before", 32'(overrun), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step_cyc();
            check("stall_beat", 32'({aso.asoValid, aso.asoChannel, aso.asoData}),
                  32'({1'b1, 1'b0, 4'd0}));
        end
        check("stall_overrun_set", 32'(overrun), 32'd1);
        enable = 1'b0;
        push(0, 0);
        push(1, 0);
        aso.asoRdy = 1'b1;
        drain("stall_release", 16);
        check("overrun_sticky", 32'(overrun), 32'd1);
        pulse_clr();
        check("overrun_cleared", 32'(overrun), 32'd0);
        push(0, 1);
        push(1, 1);
        enable = 1'b1;
        drain("after_stall", CE + 16);
        enable = 1'b0;

        // Reconfigure ch1 while its beat is presented and stalled.
        push(0, 2);
        push(1, 2);
        enable = 1'b1;
        wait_beat("stall1", 1, 2 * CE);
        aso.asoRdy = 1'b0;
        enable = 1'b0;
        step_cyc();
        check("cfg_stall_before", 32'({aso.asoValid, aso.asoChannel, aso.asoData}),
              32'({1'b1, 1'b1, 4'd2}));
        cfg(1, 1, 2);
        check("cfg_stall_after", 32'({aso.asoValid, aso.asoChannel, aso.asoData}),
              32'({1'b1, 1'b1, 4'd2}));
        step_cyc();
        check("cfg_stall_hold", 32'({aso.asoValid, aso.asoChannel, aso.asoData}),
              32'({1'b1, 1'b1, 4'd2}));
        aso.asoRdy = 1'b1;
        drain("cfg_stall_release", 16);
        pulse_clr();
        check("cfg_overrun_cleared", 32'(overrun), 32'd0);
        push(0, 3);
        push(1, 0);
        push(0, 4);
        push(1, 14);
        enable = 1'b1;
        drain("cfg_new_mode", 2 * CE + 16);
        enable = 1'b0;

        // One-cycle reset in the middle of a stalled frame.
        aso.asoRdy = 1'b0;
        enable = 1'b1;
        wait_beat("pre_reset", 0, 2 * CE);
        reset = 1'b1;
        step_cyc();
        reset = 1'b0;
        check("midreset_valid", 32'(aso.asoValid), 32'd0);
        check("midreset_channel", 32'(aso.asoChannel), 32'd0);
        check("midreset_data", 32'(aso.asoData), 32'd0);
        check("midreset_overrun", 32'(overrun), 32'd0);
        check("midreset_state", 32'(fsm_state), 32'd0);
        push(0, 0);
        push(1, 0);
        push(0, 1);
        push(1, 1);
        aso.asoRdy = 1'b1;
        drain("post_reset", 2 * CE + 16);
        enable = 1'b0;
        repeat (CE + 2) step_cyc();
        check("final_overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
